// File: rtl/sp1_ram_arb_pkg.sv
// Shared types for the sp1_ram front-end arbiter: FSM state encoding and port ids.
package sp1_ram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_A = 2'd1,
    ARB_LOCK_B = 2'd2
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // One-hot request/grant vector for a port id: bit 0 = A, bit 1 = B.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sp1_ram_arb_if.sv
// Requester-side bus of the sp1_ram arbiter; one instance per requester (A, B).
interface sp1_ram_arb_if #(
  parameter int AW = 10,
  parameter int DW = 32
) ();

  // A beat transfers on any cycle where valid & ready are both 1. ready is a
  // combinational grant and may depend on valid; the requester holds valid and
  // the request fields stable until the beat transfers. Reads return rvalid for
  // exactly one cycle, the cycle after the transfer; writes return nothing.
  logic          valid;
  logic          ready;
  logic          we;
  logic          lock;
  logic [AW-1:0] adrs;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output valid, we, lock, adrs, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, lock, adrs, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/sp1_rr_arb2.sv
// Two-way round-robin picker: grants the port not granted last when both request,
// or only the port named by i_last while i_hold is set.
module sp1_rr_arb2
  import sp1_ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_hold,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_hold) begin
      o_gnt = i_req & port_onehot(i_last);
    end else if (i_req == 2'b11) begin
      o_gnt = port_onehot(~i_last);
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/sp1_ram_arb.sv
// Two-requester arbiter in front of sp1_ram: round-robin with per-port lock, one-cycle read return.
// Optional X-check on request controls is compiled in with SP1_RAM_ARB_XCHK_EN.
module sp1_ram_arb
  import sp1_ram_arb_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  sp1_ram_arb_if.slave    a_if,
  sp1_ram_arb_if.slave    b_if,
  output logic            ram_cs,
  output logic            ram_we,
  output logic [AW-1:0]   ram_adrs,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout,
  output logic            err,
  output arb_state_e      dbg_state
);

  arb_state_e r_state;
  logic       r_last;
  logic       r_rvalid_a;
  logic       r_rvalid_b;

  logic       w_bad_a;
  logic       w_bad_b;
  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_hold;
  logic       w_last_sel;
  logic       w_acc;
  logic       w_acc_port;
  logic       w_acc_lock;

`ifdef SP1_RAM_ARB_XCHK_EN
  assign w_bad_a = $isunknown(a_if.valid) | (a_if.valid & $isunknown({a_if.we, a_if.lock}));
  assign w_bad_b = $isunknown(b_if.valid) | (b_if.valid & $isunknown({b_if.we, b_if.lock}));
`else
  assign w_bad_a = 1'b0;
  assign w_bad_b = 1'b0;
`endif

  // No grant while reset is asserted, so ram_cs and ready drop immediately.
  assign w_req = {b_if.valid & ~w_bad_b, a_if.valid & ~w_bad_a} & {2{rst}};

  assign w_hold     = (r_state != ARB_IDLE);
  assign w_last_sel = (r_state == ARB_LOCK_A) ? PORT_A :
                      (r_state == ARB_LOCK_B) ? PORT_B : r_last;

  sp1_rr_arb2 u_rr (
    .i_req  (w_req),
    .i_last (w_last_sel),
    .i_hold (w_hold),
    .o_gnt  (w_gnt)
  );

  assign w_acc      = |w_gnt;
  assign w_acc_port = w_gnt[1];
  assign w_acc_lock = w_acc_port ? b_if.lock : a_if.lock;

  assign a_if.ready = w_gnt[0];
  assign b_if.ready = w_gnt[1];

  assign ram_cs   = w_acc;
  assign ram_we   = w_acc & (w_acc_port ? b_if.we : a_if.we);
  assign ram_adrs = w_acc_port ? b_if.adrs  : a_if.adrs;
  assign ram_din  = w_acc_port ? b_if.wdata : a_if.wdata;

  assign a_if.rvalid = r_rvalid_a;
  assign b_if.rvalid = r_rvalid_b;
  assign a_if.rdata  = ram_dout;
  assign b_if.rdata  = ram_dout;

  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_last     <= PORT_B;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_a <= w_gnt[0] & ~a_if.we;
      r_rvalid_b <= w_gnt[1] & ~b_if.we;
      case (r_state)
        ARB_IDLE: begin
          if (w_acc) begin
            r_last <= w_acc_port;
            if (w_acc_lock) begin
              r_state <= w_acc_port ? ARB_LOCK_B : ARB_LOCK_A;
            end
          end
        end
        ARB_LOCK_A: begin
          if (w_gnt[0] && !a_if.lock) begin
            r_state <= ARB_IDLE;
            r_last  <= PORT_A;
          end
        end
        ARB_LOCK_B: begin
          if (w_gnt[1] && !b_if.lock) begin
            r_state <= ARB_IDLE;
            r_last  <= PORT_B;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

`ifdef SP1_RAM_ARB_XCHK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_bad_a | w_bad_b) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sp1_ram_arb.sv
// Bench for sp1_ram_arb with a behavioural sp1_ram: directed vector table, reset-mid-lock, random vs model.
module tb_sp1_ram_arb;
  import sp1_ram_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sp1_ram_arb_if #(.AW(AW), .DW(DW)) a_bus ();
  sp1_ram_arb_if #(.AW(AW), .DW(DW)) b_bus ();

  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_adrs;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          err;
  arb_state_e    dbg_state;

  sp1_ram_arb #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_if      (a_bus),
    .b_if      (b_bus),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_adrs  (ram_adrs),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Behavioural sp1_ram: synchronous read, never-written words read as zero.
  logic [DW-1:0]     ram_mem [0:(1<<AW)-1];
  logic [(1<<AW)-1:0] ram_wr = '0;
  always @(posedge clk) begin
    if (ram_cs === 1'b1) begin
      if (ram_we) begin
        ram_mem[ram_adrs] <= ram_din;
        ram_wr[ram_adrs]  <= 1'b1;
      end else begin
        ram_dout <= ram_wr[ram_adrs] ? ram_mem[ram_adrs] : '0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        av, awe, alk;
    logic [9:0]  aad;
    logic [31:0] awd;
    logic        bv, bwe, blk;
    logic [9:0]  bad;
    logic [31:0] bwd;
    logic        ear, ebr, earv, ebrv;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(input int av, awe, alk, aad, input logic [31:0] awd,
                              input int bv, bwe, blk, bad, input logic [31:0] bwd,
                              input int ear, ebr, earv, ebrv, input logic [31:0] erd);
    vec_t v;
    v.av = (av != 0); v.awe = (awe != 0); v.alk = (alk != 0); v.aad = 10'(aad); v.awd = awd;
    v.bv = (bv != 0); v.bwe = (bwe != 0); v.blk = (blk != 0); v.bad = 10'(bad); v.bwd = bwd;
    v.ear = (ear != 0); v.ebr = (ebr != 0); v.earv = (earv != 0); v.ebrv = (ebrv != 0);
    v.erd = erd;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    a_bus.valid = v.av; a_bus.we = v.awe; a_bus.lock = v.alk; a_bus.adrs = v.aad; a_bus.wdata = v.awd;
    b_bus.valid = v.bv; b_bus.we = v.bwe; b_bus.lock = v.blk; b_bus.adrs = v.bad; b_bus.wdata = v.bwd;
  endtask

  task automatic drive_idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("v%0d a_ready", idx), 32'(a_bus.ready), 32'(v.ear));
    chk($sformatf("v%0d b_ready", idx), 32'(b_bus.ready), 32'(v.ebr));
    chk($sformatf("v%0d ram_cs", idx), 32'(ram_cs), 32'(v.ear | v.ebr));
    chk($sformatf("v%0d a_rvalid", idx), 32'(a_bus.rvalid), 32'(v.earv));
    chk($sformatf("v%0d b_rvalid", idx), 32'(b_bus.rvalid), 32'(v.ebrv));
    if (v.earv) chk($sformatf("v%0d a_rdata", idx), a_bus.rdata, v.erd);
    if (v.ebrv) chk($sformatf("v%0d b_rdata", idx), b_bus.rdata, v.erd);
  endtask

  // ---------------- reference model state ----------------
  int          m_own;
  int          m_last;
  int          m_pend;
  logic [31:0] m_pdata;
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input int adr);
    return ref_mem.exists(adr) ? ref_mem[adr] : 32'h0;
  endfunction

  vec_t vecs[$];

  initial begin
    drive_idle();

    // Reset state, with A requesting during reset.
    #12;
    a_bus.valid = 1'b1;
    #1;
    chk("rst ram_cs", 32'(ram_cs), 0);
    chk("rst a_ready", 32'(a_bus.ready), 0);
    chk("rst a_rvalid", 32'(a_bus.rvalid), 0);
    chk("rst b_rvalid", 32'(b_bus.rvalid), 0);
    chk("rst err", 32'(err), 0);
    chk("rst state", 32'(dbg_state), 32'(ARB_IDLE));

    // Directed table: alternation, write/read, lock, B burst.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 0, 'h005, 0, 1, 0, 0, 'h006, 0,
                        (i % 2 == 0), (i % 2 == 1), (i == 1 || i == 3), (i == 2), 0));
    vecs.push_back(mk(1, 1, 0, 'h000, 32'hcafecafe, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 'h000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hcafecafe));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 'h010, 32'h12345678, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 'h3ff, 0, 1, 0, 0, 'h010, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 'h010, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 'h3ff, 32'hbeefbeef, 1, 0, 0, 'h010, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 'h010, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678));
    vecs.push_back(mk(1, 0, 0, 'h3ff, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hbeefbeef));
    begin
      logic [31:0] pat [4];
      pat[0] = 32'h33333333; pat[1] = 32'hcccccccc; pat[2] = 32'h55555555; pat[3] = 32'haaaaaaaa;
      for (int i = 0; i < 4; i++)
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1 + i, pat[i], 0, 1, 0, 0, 0));
      for (int i = 0; i < 5; i++)
        vecs.push_back(mk(0, 0, 0, 0, 0, (i < 4), 0, 0, 1 + i, 0, 0, (i < 4), 0, (i > 0),
                          (i > 0) ? pat[i-1] : 32'h0));
    end

    do_reset();
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset asserted mid-lock with an A read in flight.
    do_reset();
    @(negedge clk);
    drive(mk(1, 0, 1, 'h3ff, 0, 1, 0, 0, 'h020, 0, 0, 0, 0, 0, 0));
    #1;
    chk("ml first a_ready", 32'(a_bus.ready), 1);
    chk("ml first b_ready", 32'(b_bus.ready), 0);
    @(negedge clk);
    #1;
    chk("ml locked a_ready", 32'(a_bus.ready), 1);
    chk("ml locked b_ready", 32'(b_bus.ready), 0);
    chk("ml locked state", 32'(dbg_state), 32'(ARB_LOCK_A));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ml rst a_rvalid", 32'(a_bus.rvalid), 0);
    chk("ml rst b_rvalid", 32'(b_bus.rvalid), 0);
    chk("ml rst ram_cs", 32'(ram_cs), 0);
    chk("ml rst state", 32'(dbg_state), 32'(ARB_IDLE));
    @(negedge clk);
    rst = 1'b1;
    drive(mk(1, 0, 0, 'h005, 0, 1, 0, 0, 'h006, 0, 0, 0, 0, 0, 0));
    #1;
    chk("ml post a_ready", 32'(a_bus.ready), 1);
    chk("ml post b_ready", 32'(b_bus.ready), 0);

    // Randomized traffic against the reference model.
    do_reset();
    m_own = -1; m_last = 1; m_pend = -1; m_pdata = '0;
    for (int c = 0; c < 400; c++) begin
      vec_t v;
      int   g;
      int   adr;
      v = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
             'h100 + $urandom_range(0, 15), $urandom,
             ($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
             'h100 + $urandom_range(0, 15), $urandom, 0, 0, 0, 0, 0);
      @(negedge clk);
      drive(v);
      if (m_own == 0)               g = v.av ? 0 : -1;
      else if (m_own == 1)          g = v.bv ? 1 : -1;
      else if (v.av && v.bv)        g = 1 - m_last;
      else if (v.av)                g = 0;
      else if (v.bv)                g = 1;
      else                          g = -1;
      #1;
      chk($sformatf("r%0d a_ready", c), 32'(a_bus.ready), 32'(g == 0));
      chk($sformatf("r%0d b_ready", c), 32'(b_bus.ready), 32'(g == 1));
      chk($sformatf("r%0d ram_cs", c), 32'(ram_cs), 32'(g >= 0));
      chk($sformatf("r%0d a_rvalid", c), 32'(a_bus.rvalid), 32'(m_pend == 0));
      chk($sformatf("r%0d b_rvalid", c), 32'(b_bus.rvalid), 32'(m_pend == 1));
      if (m_pend == 0) chk($sformatf("r%0d a_rdata", c), a_bus.rdata, m_pdata);
      if (m_pend == 1) chk($sformatf("r%0d b_rdata", c), b_bus.rdata, m_pdata);
      m_pend = -1;
      if (g >= 0) begin
        logic we, lk;
        logic [31:0] wd;
        adr = (g == 0) ? int'(v.aad) : int'(v.bad);
        we  = (g == 0) ? v.awe : v.bwe;
        lk  = (g == 0) ? v.alk : v.blk;
        wd  = (g == 0) ? v.awd : v.bwd;
        chk($sformatf("r%0d ram_adrs", c), 32'(ram_adrs), 32'(adr));
        chk($sformatf("r%0d ram_we", c), 32'(ram_we), 32'(we));
        if (we) begin
          chk($sformatf("r%0d ram_din", c), ram_din, wd);
          ref_mem[adr] = wd;
        end else begin
          m_pend  = g;
          m_pdata = ref_rd(adr);
        end
        m_own  = lk ? g : -1;
        m_last = g;
      end
    end

`ifdef SP1_RAM_ARB_XCHK_EN
    do_reset();
    @(negedge clk);
    a_bus.valid = 1'b1;
    a_bus.we    = 1'bx;
    #1;
    chk("xchk a_ready", 32'(a_bus.ready), 0);
    chk("xchk ram_cs", 32'(ram_cs), 0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("xchk err set", 32'(err), 1);
    @(negedge clk);
    #1;
    chk("xchk err sticky", 32'(err), 1);
`else
    chk("err off", 32'(err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
